dut_collector: RTL and testbench
================================

DUT_COLLECTOR -- requirements
Module: dut_collector

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the data width of every input channel and of the output.
REQ-002 The block SHALL have parameter DEPTH, fixed at 2, meaning the entries per input FIFO; no other value is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 i_data0..i_data3  input  DW each  channel N data word.
REQ-006 i_valid0..i_valid3  input  1 each  channel N word present.
REQ-007 o_ready0..o_ready3  output  1 each  channel N can accept a word.
REQ-008 o_data  output  DW  merged output data word.
REQ-009 o_id  output  2  source channel index of o_data.
REQ-010 o_valid  output  1  o_data/o_id valid.
REQ-011 i_ready  input  1  downstream accepts the output word.

Function
REQ-012 Each channel N SHALL own a 2-entry FIFO with a registered occupancy count of 0..2.
REQ-013 o_readyN SHALL equal (countN < 2), taken from registered state only; a same-cycle pop SHALL NOT raise o_readyN while the FIFO is full.
REQ-014 Push on channel N SHALL occur when i_validN && o_readyN; the FIFO SHALL capture i_dataN at that edge.
REQ-015 i_dataN SHALL be ignored when i_validN=0 or o_readyN=0; no word is lost or duplicated.
REQ-016 The output SHALL be a single register stage holding o_data, o_id and o_valid.
REQ-017 The output stage SHALL load when (!o_valid || i_ready) and at least one FIFO is non-empty.
REQ-018 Grant SHALL be round-robin: search starts at channel (last_grant+1) mod 4 and takes the first non-empty FIFO.
REQ-019 A load SHALL pop the granted FIFO head into o_data, set o_id to the granted index and set o_valid=1.
REQ-020 A load SHALL update last_grant to the granted index; last_grant SHALL remain unchanged when no load occurs.
REQ-021 When i_ready=1, o_valid=1 and all FIFOs are empty, o_valid SHALL drop to 0 at the next edge.
REQ-022 While o_valid=1 and i_ready=0, o_data, o_id and o_valid SHALL hold stable (no change, no pop).
REQ-023 Latency: a word pushed at edge k SHALL be visible on o_data no earlier than after edge k+1 (2 cycles from i_valid sample to o_valid), given an idle output and no competing channel.
REQ-024 Push and pop on the same FIFO in the same cycle SHALL leave its count unchanged and preserve FIFO order.
REQ-025 Per-channel order SHALL be preserved at the output; words from different channels MAY interleave per REQ-018.
REQ-026 With all four channels continuously non-empty and i_ready=1, grants SHALL be 0,1,2,3,0,... and throughput SHALL be one word per cycle.

Reset
REQ-027 While resetn=0 at a rising edge, every FIFO count SHALL be set to 0, o_valid SHALL be set to 0, o_data to 0 and o_id to 0.
REQ-028 While resetn=0 at a rising edge, last_grant SHALL be set to 3 so that the first grant after reset searches from channel 0.
REQ-029 A reset asserted mid-transfer SHALL discard all buffered words and any held output word; no partial state survives.
REQ-030 o_readyN SHALL read 1 in the first cycle after reset deasserts.

Verification
REQ-031 Single word: after reset, i_valid2=1, i_data2=0x5A for one cycle, i_ready=1 -> two cycles later o_valid=1, o_data=0x5A, o_id=2 for one cycle.
REQ-032 Round-robin: all channels push 0x10+N every cycle, i_ready=1 -> o_id sequence 0,1,2,3,0,..., o_data=0x10+o_id, no gaps after the first word.
REQ-033 Backpressure: i_ready=0, channel 0 pushes 0x01,0x02,0x03,0x04 -> o_ready0=0 after two pushes plus the output-register fill (3 words held); o_data holds 0x01; on raising i_ready, 0x01,0x02,0x03 appear in order, and 0x04 is accepted only once o_ready0 returns to 1.
REQ-034 Full FIFO with simultaneous pop: channel 1 full, i_ready=1, i_valid1=1 -> no push that cycle (o_ready1=0), count goes 2->1, push accepted the following cycle.
REQ-035 Reset mid-operation: FIFOs holding data, o_valid=1, resetn=0 for one edge -> o_valid=0, all o_readyN=1, and the next grant goes to the lowest non-empty channel starting from 0.
REQ-036 Empty drain: a single word is consumed with i_ready=1 and no further pushes -> o_valid=0 at the next edge, o_data holds its last value, last_grant is unchanged.

Source files
------------

// File: rtl/dut_collector.sv
// Four-channel collector: each input channel owns a two-entry FIFO and a
// round-robin arbiter drains them into a single registered output stage.
module dut_collector #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] i_data0,
  input  logic [DW-1:0] i_data1,
  input  logic [DW-1:0] i_data2,
  input  logic [DW-1:0] i_data3,
  input  logic          i_valid0,
  input  logic          i_valid1,
  input  logic          i_valid2,
  input  logic          i_valid3,
  output logic          o_ready0,
  output logic          o_ready1,
  output logic          o_ready2,
  output logic          o_ready3,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_id,
  output logic          o_valid,
  input  logic          i_ready
);

  logic [DW-1:0] data_in [4];
  logic [3:0]    valid_in;
  logic [3:0]    ready;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic [1:0]    count [4];
  logic [DW-1:0] mem [4][DEPTH];
  logic [1:0]    last_grant;
  logic [1:0]    grant;
  logic [1:0]    idx;
  logic          any;
  logic          load;

  assign data_in[0] = i_data0;
  assign data_in[1] = i_data1;
  assign data_in[2] = i_data2;
  assign data_in[3] = i_data3;
  assign valid_in   = {i_valid3, i_valid2, i_valid1, i_valid0};

  // Readiness depends only on registered occupancy, so a pop never unblocks a full FIFO early.
  always_comb begin
    ready = '0;
    for (int n = 0; n < 4; n++) ready[n] = (count[n] < 2'(DEPTH));
  end

  assign push     = valid_in & ready;
  assign o_ready0 = ready[0];
  assign o_ready1 = ready[1];
  assign o_ready2 = ready[2];
  assign o_ready3 = ready[3];

  // Scan from last_grant+1; walking offsets downwards lets the nearest non-empty channel win.
  always_comb begin
    grant = last_grant;
    any   = 1'b0;
    idx   = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (count[idx] != 2'd0) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

  assign load = (!o_valid || i_ready) && any;

  always_comb begin
    pop = '0;
    for (int n = 0; n < 4; n++) pop[n] = load && (grant == 2'(n));
  end

  // Entry 0 is always the head; a pop shifts entry 1 down, a simultaneous push refills the head.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int n = 0; n < 4; n++) count[n] <= 2'd0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (pop[n]) begin
          mem[n][0] <= push[n] ? data_in[n] : mem[n][1];
          if (!push[n]) count[n] <= count[n] - 2'd1;
        end else if (push[n]) begin
          mem[n][count[n][0]] <= data_in[n];
          count[n] <= count[n] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_id       <= 2'd0;
      last_grant <= 2'd3;
    end else if (load) begin
      o_data     <= mem[grant][0];
      o_id       <= grant;
      o_valid    <= 1'b1;
      last_grant <= grant;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dut_collector.sv
// Randomized self-checking bench for dut_collector, compared every cycle
// against a queue-based reference model of the collector's behaviour.
module tb_dut_collector;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] din [4];
  logic [3:0]    vin;
  logic          i_ready;
  logic          o_ready0, o_ready1, o_ready2, o_ready3;
  logic [DW-1:0] o_data;
  logic [1:0]    o_id;
  logic          o_valid;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q [4][$];
  logic          mv;
  logic [DW-1:0] md;
  logic [1:0]    mid;
  int            lastg;

  always #5 clk = ~clk;

  dut_collector #(.DW(DW), .DEPTH(2)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i_data0  (din[0]),
    .i_data1  (din[1]),
    .i_data2  (din[2]),
    .i_data3  (din[3]),
    .i_valid0 (vin[0]),
    .i_valid1 (vin[1]),
    .i_valid2 (vin[2]),
    .i_valid3 (vin[3]),
    .o_ready0 (o_ready0),
    .o_ready1 (o_ready1),
    .o_ready2 (o_ready2),
    .o_ready3 (o_ready3),
    .o_data   (o_data),
    .o_id     (o_id),
    .o_valid  (o_valid),
    .i_ready  (i_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs currently driven.
  task automatic modelEdge();
    bit   accept [4];
    int   g;
    int   c;
    if (!resetn) begin
      for (int n = 0; n < 4; n++) q[n].delete();
      mv    = 1'b0;
      md    = '0;
      mid   = 2'd0;
      lastg = 3;
    end else begin
      for (int n = 0; n < 4; n++) accept[n] = vin[n] && (q[n].size() < 2);
      g = -1;
      if (!mv || i_ready) begin
        for (int k = 1; k <= 4; k++) begin
          c = (lastg + k) % 4;
          if (g < 0 && q[c].size() > 0) g = c;
        end
      end
      if (g >= 0) begin
        md    = q[g].pop_front();
        mid   = 2'(g);
        mv    = 1'b1;
        lastg = g;
      end else if (i_ready) begin
        mv = 1'b0;
      end
      for (int n = 0; n < 4; n++) if (accept[n]) q[n].push_back(din[n]);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                               input logic rdy, input logic rst_n);
    logic [3:0] exp_ready;
    @(negedge clk);
    vin     = v;
    din[0]  = d0;
    din[1]  = d1;
    din[2]  = d2;
    din[3]  = d3;
    i_ready = rdy;
    resetn  = rst_n;
    #1;
    for (int n = 0; n < 4; n++) exp_ready[n] = (q[n].size() < 2);
    checkOutput("ready", {28'd0, o_ready3, o_ready2, o_ready1, o_ready0}, {28'd0, exp_ready});
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("o_valid", {31'd0, o_valid}, {31'd0, mv});
    checkOutput("o_data", {24'd0, o_data}, {24'd0, md});
    checkOutput("o_id", {30'd0, o_id}, {30'd0, mid});
  endtask

  task automatic idle(input logic rdy, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(4'b0, '0, '0, '0, '0, rdy, 1'b1);
  endtask

  initial begin
    vin = '0; i_ready = 1'b0; resetn = 1'b0;
    for (int n = 0; n < 4; n++) din[n] = '0;
    mv = 1'b0; md = '0; mid = 2'd0; lastg = 3;

    applyStimulus(4'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset_data", {24'd0, o_data}, 32'd0);
    checkOutput("reset_id", {30'd0, o_id}, 32'd0);

    // Single word on channel 2
    applyStimulus(4'b0100, '0, '0, 8'h5A, '0, 1'b1, 1'b1);
    checkOutput("single_not_yet", {31'd0, o_valid}, 32'd0);
    applyStimulus(4'b0, '0, '0, '0, '0, 1'b1, 1'b1);
    checkOutput("single_valid", {31'd0, o_valid}, 32'd1);
    checkOutput("single_data", {24'd0, o_data}, 32'h5A);
    checkOutput("single_id", {30'd0, o_id}, 32'd2);
    applyStimulus(4'b0, '0, '0, '0, '0, 1'b1, 1'b1);
    checkOutput("drain_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("drain_hold", {24'd0, o_data}, 32'h5A);

    // All channels streaming
    for (int i = 0; i < 16; i++) applyStimulus(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1, 1'b1);
    idle(1'b1, 10);

    // Backpressure on channel 0
    applyStimulus(4'b0001, 8'h01, '0, '0, '0, 1'b0, 1'b1);
    applyStimulus(4'b0001, 8'h02, '0, '0, '0, 1'b0, 1'b1);
    applyStimulus(4'b0001, 8'h03, '0, '0, '0, 1'b0, 1'b1);
    checkOutput("bp_ready0", {31'd0, o_ready0}, 32'd0);
    checkOutput("bp_hold", {24'd0, o_data}, 32'h01);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 8'h04, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 8'h04, '0, '0, '0, 1'b1, 1'b1);
    idle(1'b1, 5);

    // Reset with data buffered and output held, then resume
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0, 1'b1);
    applyStimulus(4'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("midreset_valid", {31'd0, o_valid}, 32'd0);
    applyStimulus(4'b1010, '0, 8'hB1, '0, 8'hB3, 1'b1, 1'b1);
    applyStimulus(4'b0, '0, '0, '0, '0, 1'b1, 1'b1);
    checkOutput("after_reset_id", {30'd0, o_id}, 32'd1);
    idle(1'b1, 4);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      applyStimulus(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
    end
    idle(1'b1, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
